// File: rtl/n64_controller_responder.sv
// n64_controller_responder: emulated N64 controller answering console commands on the single-wire link
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   gpio_in       raw (asynchronous) line level
//   gpio_out      open-collector drive, 0 when pulling low, Z otherwise
//   button_data   32-bit button word, MSB first, latched when a 0x01 poll is decoded
//   poll_strobe   1-cycle pulse as a poll response starts
//   reset_strobe  1-cycle pulse when a 0xFF command is decoded
//   busy          high whenever the responder is not idle
//   rx_error      1-cycle pulse on receive timeout, over-long low or unknown command
module n64_controller_responder #(
    parameter int CLKS_PER_US = 100,
    parameter int TURNAROUND  = 200,
    parameter int RX_TIMEOUT  = 800,
    parameter int LOW_MAX     = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gpio_in,
    output logic        gpio_out,
    input  logic [31:0] button_data,
    output logic        poll_strobe,
    output logic        reset_strobe,
    output logic        busy,
    output logic        rx_error
);
    localparam int M1   = (4 * CLKS_PER_US > RX_TIMEOUT) ? 4 * CLKS_PER_US : RX_TIMEOUT;
    localparam int M2   = (TURNAROUND > LOW_MAX + 1) ? TURNAROUND : LOW_MAX + 1;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXC + 1) + 1;
    localparam logic [CW-1:0] C_ONE     = CW'(CLKS_PER_US);
    localparam logic [CW-1:0] C_SAMPLE  = CW'(2 * CLKS_PER_US);
    localparam logic [CW-1:0] C_ZERO    = CW'(3 * CLKS_PER_US);
    localparam logic [CW-1:0] C_BIT_END = CW'(4 * CLKS_PER_US - 1);
    localparam logic [CW-1:0] C_STOP    = CW'(2 * CLKS_PER_US);
    localparam logic [CW-1:0] C_TURN    = CW'(TURNAROUND - 1);
    localparam logic [CW-1:0] C_TIMEOUT = CW'(RX_TIMEOUT);
    localparam logic [CW-1:0] C_LOWMAX  = CW'(LOW_MAX);

    typedef enum logic [2:0] {IDLE, RX_BIT, RX_STOP, TURN, TX_BIT, TX_STOP, RX_FLUSH} state_t;

    state_t        state, state_n;
    logic [1:0]    sync;
    logic          line, line_d, fall, rise;
    logic [CW-1:0] cnt, cnt_n, cnt_inc, low_cnt, low_n;
    logic [2:0]    bit_cnt, bit_n;
    logic          got, got_n, stop_low, stop_n;
    logic [7:0]    cmd, cmd_n;
    logic [31:0]   tx_shift, tx_n;
    logic [5:0]    tx_left, left_n;
    logic          is_poll, is_poll_n, drive_low, drive_n;
    logic          poll_n, rst_n, err_n, rx_bad;

    assign line     = sync[1];
    assign fall     = line_d & ~line;
    assign rise     = ~line_d & line;
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
    // Timeout is checked before the falling edge so a coincident edge still counts as a timeout
    assign rx_bad   = (cnt >= C_TIMEOUT) || (low_cnt > C_LOWMAX);
    assign busy     = state != IDLE;
    assign gpio_out = drive_low ? 1'b0 : 1'bz;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt_inc;
        low_n     = line ? '0 : ((low_cnt > C_LOWMAX) ? low_cnt : low_cnt + 1'b1);
        bit_n     = bit_cnt;
        got_n     = got;
        stop_n    = stop_low;
        cmd_n     = cmd;
        tx_n      = tx_shift;
        left_n    = tx_left;
        is_poll_n = is_poll;
        poll_n    = 1'b0;
        rst_n     = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_n = RX_BIT;
                    cnt_n   = '0;
                    bit_n   = '0;
                    got_n   = 1'b0;
                end
            end
            RX_BIT: begin
                if (rx_bad) begin
                    err_n   = 1'b1;
                    state_n = RX_FLUSH;
                    cnt_n   = '0;
                end else if (fall) begin
                    cnt_n = '0;
                    got_n = 1'b0;
                end else if (!got && cnt == C_SAMPLE) begin
                    cmd_n = {cmd[6:0], line};
                    got_n = 1'b1;
                    bit_n = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_n = RX_STOP;
                        stop_n  = 1'b0;
                    end
                end
            end
            RX_STOP: begin
                // A rise before the stop-bit fall is the tail of a trailing '0' bit and is ignored
                if (rx_bad) begin
                    err_n   = 1'b1;
                    state_n = RX_FLUSH;
                    cnt_n   = '0;
                end else if (fall) begin
                    cnt_n  = '0;
                    stop_n = 1'b1;
                end else if (rise && stop_low) begin
                    cnt_n = '0;
                    if (cmd == 8'h01) begin
                        tx_n      = button_data;
                        left_n    = 6'd32;
                        is_poll_n = 1'b1;
                        state_n   = TURN;
                    end else if (cmd == 8'h00 || cmd == 8'hFF) begin
                        tx_n      = {24'h050002, 8'h00};
                        left_n    = 6'd24;
                        is_poll_n = 1'b0;
                        rst_n     = cmd == 8'hFF;
                        state_n   = TURN;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            RX_FLUSH: begin
                cnt_n = line ? cnt_inc : '0;
                if (line && cnt == C_TIMEOUT - 1'b1) state_n = IDLE;
            end
            TURN: begin
                if (cnt == C_TURN) begin
                    state_n = TX_BIT;
                    cnt_n   = '0;
                    poll_n  = is_poll;
                end
            end
            TX_BIT: begin
                if (cnt == C_BIT_END) begin
                    cnt_n   = '0;
                    tx_n    = {tx_shift[30:0], 1'b0};
                    left_n  = tx_left - 1'b1;
                    state_n = (tx_left == 6'd1) ? TX_STOP : TX_BIT;
                end
            end
            TX_STOP: begin
                if (cnt == C_STOP - 1'b1) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Drive is registered from next-state values so the line edge lines up with the state change
        drive_n = (state_n == TX_BIT && cnt_n < (tx_n[31] ? C_ONE : C_ZERO)) ||
                  (state_n == TX_STOP && cnt_n < C_STOP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sync         <= 2'b11;
            line_d       <= 1'b1;
            cnt          <= '0;
            low_cnt      <= '0;
            bit_cnt      <= '0;
            got          <= 1'b0;
            stop_low     <= 1'b0;
            cmd          <= '0;
            tx_shift     <= '0;
            tx_left      <= '0;
            is_poll      <= 1'b0;
            drive_low    <= 1'b0;
            poll_strobe  <= 1'b0;
            reset_strobe <= 1'b0;
            rx_error     <= 1'b0;
        end else begin
            state        <= state_n;
            sync         <= {sync[0], gpio_in};
            line_d       <= sync[1];
            cnt          <= cnt_n;
            low_cnt      <= low_n;
            bit_cnt      <= bit_n;
            got          <= got_n;
            stop_low     <= stop_n;
            cmd          <= cmd_n;
            tx_shift     <= tx_n;
            tx_left      <= left_n;
            is_poll      <= is_poll_n;
            drive_low    <= drive_n;
            poll_strobe  <= poll_n;
            reset_strobe <= rst_n;
            rx_error     <= err_n;
        end
    end
endmodule

// File: tb/tb_n64_controller_responder.sv
// tb_n64_controller_responder: console-side stimulus with a scoreboard decoding the responder's pulses
module tb_n64_controller_responder;
    localparam int US = 50;
    localparam int TA = 100;
    localparam int TO = 400;
    localparam int LM = 250;

    typedef struct {
        int          len;
        logic [31:0] val;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        con_low = 1'b0;
    logic [31:0] button_data = 32'h8000_1234;
    wire         gpio_out;
    logic        gpio_in, poll_strobe, reset_strobe, busy, rx_error;

    int          vectors = 0, miscompares = 0;
    int          poll_cnt = 0, rst_cnt = 0, err_cnt = 0, drv_cnt = 0;
    resp_t       exp_q[$];
    resp_t       e;
    int          low_len = 0, nbits = 0;
    logic [31:0] bits = '0;

    pullup (gpio_out);
    assign gpio_in = !con_low && (gpio_out !== 1'b0);

    always #5 clk = ~clk;

    n64_controller_responder #(
        .CLKS_PER_US(US), .TURNAROUND(TA), .RX_TIMEOUT(TO), .LOW_MAX(LM)
    ) dut (
        .clk(clk), .reset(reset), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .button_data(button_data), .poll_strobe(poll_strobe),
        .reset_strobe(reset_strobe), .busy(busy), .rx_error(rx_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        poll_cnt += int'(poll_strobe);
        rst_cnt  += int'(reset_strobe);
        err_cnt  += int'(rx_error);
        drv_cnt  += int'(gpio_out === 1'b0);
    end

    always @(negedge clk) begin
        if (reset) begin
            low_len = 0;
            nbits   = 0;
            bits    = '0;
            exp_q.delete();
        end else if (gpio_out === 1'b0) begin
            low_len++;
        end else if (low_len != 0) begin
            if (low_len == 2 * US) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_response: got %0d bits %h expected none", nbits, bits);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_len", nbits, e.len);
                    check("resp_data", bits, e.val);
                end
                nbits = 0;
                bits  = '0;
            end else if (low_len == US || low_len == 3 * US) begin
                bits = {bits[30:0], low_len == US};
                nbits++;
            end else begin
                vectors++;
                miscompares++;
                $display("FAIL pulse_width: got %0d cycles expected %0d/%0d/%0d", low_len, US, 2 * US, 3 * US);
            end
            low_len = 0;
        end
    end

    task automatic send_bits(input logic [7:0] b, input int n, input bit stop);
        for (int i = 7; i > 7 - n; i--) begin
            con_low = 1'b1;
            repeat (b[i] ? US : 3 * US) @(negedge clk);
            con_low = 1'b0;
            repeat (b[i] ? 3 * US : US) @(negedge clk);
        end
        if (stop) begin
            con_low = 1'b1;
            repeat (US) @(negedge clk);
            con_low = 1'b0;
        end
    endtask

    task automatic wait_gap();
        int n = 0;
        while (gpio_out !== 1'b0 && n < TA + 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n < TA + 1 || n > TA + 6) begin
            miscompares++;
            $display("FAIL turnaround_gap: got %0d cycles expected %0d..%0d", n, TA + 1, TA + 6);
        end
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 1'b0);
    endtask

    task automatic do_resp(input logic [7:0] c, input int len, input logic [31:0] val,
                           input int ep, input int er, input int chg_bit);
        int p0 = poll_cnt, r0 = rst_cnt, e0 = err_cnt;
        exp_q.push_back('{len, val});
        send_bits(c, 8, 1'b1);
        wait_gap();
        if (chg_bit > 0) begin
            repeat ((chg_bit - 1) * 4 * US + 2 * US) @(negedge clk);
            button_data = 32'h0;
        end
        wait_idle(len * 4 * US + 4 * US + 100);
        repeat (20) @(negedge clk);
        check("poll_strobes", poll_cnt - p0, ep);
        check("reset_strobes", rst_cnt - r0, er);
        check("rx_errors", err_cnt - e0, 0);
        button_data = 32'h8000_1234;
    endtask

    initial begin
        int n, e0, d0, p0;
        repeat (5) @(negedge clk);
        check("rst_gpio_out", gpio_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_poll_strobe", poll_strobe, 1'b0);
        check("rst_reset_strobe", reset_strobe, 1'b0);
        check("rst_rx_error", rx_error, 1'b0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        do_resp(8'h01, 32, 32'h8000_1234, 1, 0, 0);
        do_resp(8'h00, 24, 32'h0005_0002, 0, 0, 0);
        do_resp(8'hFF, 24, 32'h0005_0002, 0, 1, 0);

        e0 = err_cnt;
        d0 = drv_cnt;
        send_bits(8'h55, 8, 1'b1);
        n = 0;
        while (!rx_error && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bad_cmd_rx_error", rx_error, 1'b1);
        check("bad_cmd_busy", busy, 1'b0);
        repeat (1000) @(negedge clk);
        check("bad_cmd_err_count", err_cnt - e0, 1);
        check("bad_cmd_no_drive", drv_cnt - d0, 0);

        e0 = err_cnt;
        d0 = drv_cnt;
        send_bits(8'h00, 3, 1'b0);
        con_low = 1'b1;
        repeat (LM + LM / 5) @(negedge clk);
        con_low = 1'b0;
        repeat (TO - 20) @(negedge clk);
        check("flush_busy_held", busy, 1'b1);
        repeat (40) @(negedge clk);
        check("flush_busy_released", busy, 1'b0);
        check("long_low_err_count", err_cnt - e0, 1);
        check("long_low_no_drive", drv_cnt - d0, 0);
        repeat (20) @(negedge clk);

        p0 = poll_cnt;
        exp_q.push_back('{32, 32'h8000_1234});
        send_bits(8'h01, 8, 1'b1);
        wait_gap();
        repeat (9 * 4 * US + US) @(negedge clk);
        check("pre_reset_drive", gpio_out, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("reset_release_line", gpio_out, 1'b1);
        check("reset_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("reset_poll_strobes", poll_cnt - p0, 1);

        do_resp(8'h01, 32, 32'h8000_1234, 1, 0, 5);

        check("queue_empty", exp_q.size(), 0);
        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        repeat (90000) @(negedge clk);
        $display("FAIL watchdog: got no completion expected finish within 90000 cycles");
        $fatal(1, "watchdog");
    end
endmodule
